// File: rtl/fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// fetch_stage_pkg
// Shared constants and types for the instruction-fetch stage:
//   WORD_LEN_DEF : default width of PC, addresses and instructions
//   PC_INC       : sequential PC increment (one 32-bit instruction)
//   ZERO / ONE   : single-bit constants
//   fetch_state_e: FETCH_ST (requesting) / HOLD_ST (instruction parked in buffer)
// -----------------------------------------------------------------------------
package fetch_stage_pkg;

    localparam int WORD_LEN_DEF = 32;
    localparam int PC_INC       = 4;

    localparam logic ZERO = 1'b0;
    localparam logic ONE  = 1'b1;

    typedef enum logic {
        FETCH_ST = 1'b0,
        HOLD_ST  = 1'b1
    } fetch_state_e;

endpackage : fetch_stage_pkg

// File: rtl/fetch_stage_if_id_reg.sv
// -----------------------------------------------------------------------------
// fetch_stage_if_id_reg
// IF/ID pipeline register between fetch and decode.
// Priority: flush > freeze > bubble > load.
//   clk, rst_n     : clock, async active-low reset (clears all fields)
//   i_flush        : clear valid, pc and instr (taken branch)
//   i_freeze       : hold every field (pipeline stall)
//   i_bubble       : clear valid only; pc/instr keep their last value
//   i_pc, i_instr  : PC+4 and instruction to capture when loading
//   o_valid, o_pc, o_instr : registered IF/ID contents
// -----------------------------------------------------------------------------
module fetch_stage_if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter int WORD_LEN = WORD_LEN_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_flush,
    input  logic                i_freeze,
    input  logic                i_bubble,
    input  logic [WORD_LEN-1:0] i_pc,
    input  logic [WORD_LEN-1:0] i_instr,
    output logic                o_valid,
    output logic [WORD_LEN-1:0] o_pc,
    output logic [WORD_LEN-1:0] o_instr
);

    logic                r_valid;
    logic [WORD_LEN-1:0] r_pc;
    logic [WORD_LEN-1:0] r_instr;

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= ZERO;
            r_pc    <= '0;
            r_instr <= '0;
        end else if (i_flush) begin
            r_valid <= ZERO;
            r_pc    <= '0;
            r_instr <= '0;
        end else if (i_freeze) begin
            r_valid <= r_valid;
        end else if (i_bubble) begin
            r_valid <= ZERO;
        end else begin
            r_valid <= ONE;
            r_pc    <= i_pc;
            r_instr <= i_instr;
        end
    end

    assign o_valid = r_valid;
    assign o_pc    = r_pc;
    assign o_instr = r_instr;

endmodule : fetch_stage_if_id_reg

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage: PC, level-sensitive instruction-memory request,
// one-entry hold buffer for instructions returned during a stall, and the
// IF/ID pipeline register (fetch_stage_if_id_reg).
//
// Optional feature macro: FETCH_STALL_CNT_EN adds the stall_count port, a
// saturating count of cycles with hazard=1 and branch_taken=0.
//
// Ports:
//   clk, rst_n     : clock (rising edge), async active-low reset
//   hazard         : stall request; freezes PC and IF/ID
//   branch_taken   : redirect to branch_addr; flushes IF/ID and hold buffer
//   branch_addr    : branch target (used unaligned as given)
//   imem_req       : fetch request (level), high in FETCH state
//   imem_addr      : fetch address (= current PC)
//   imem_ready     : imem_rdata valid; completes the request
//   imem_rdata     : fetched instruction
//   if_id_valid/if_id_pc/if_id_instr : IF/ID register (pc = PC+4)
//   stall_count    : [FETCH_STALL_CNT_EN only] saturating stall counter
// -----------------------------------------------------------------------------
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int                  WORD_LEN = WORD_LEN_DEF,
    parameter logic [WORD_LEN-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                hazard,
    input  logic                branch_taken,
    input  logic [WORD_LEN-1:0] branch_addr,
    output logic                imem_req,
    output logic [WORD_LEN-1:0] imem_addr,
    input  logic                imem_ready,
    input  logic [WORD_LEN-1:0] imem_rdata,
    output logic                if_id_valid,
    output logic [WORD_LEN-1:0] if_id_pc,
    output logic [WORD_LEN-1:0] if_id_instr
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [31:0]         stall_count
`endif
);

    fetch_state_e        r_state;
    logic [WORD_LEN-1:0] r_pc;
    logic [WORD_LEN-1:0] r_hold_instr;
    logic [WORD_LEN-1:0] r_hold_pc4;

    logic [WORD_LEN-1:0] w_pc4;
    logic                w_freeze;
    logic                w_bubble;
    logic [WORD_LEN-1:0] w_load_pc;
    logic [WORD_LEN-1:0] w_load_instr;

    // Wraps modulo 2^WORD_LEN.
    assign w_pc4 = r_pc + WORD_LEN'(PC_INC);

    assign imem_req  = (r_state == FETCH_ST);
    assign imem_addr = r_pc;

    // IF/ID control. A flush (branch_taken) takes priority inside the register.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_freeze     = ZERO;
        w_bubble     = ZERO;
        w_load_pc    = w_pc4;
        w_load_instr = imem_rdata;
        if (r_state == FETCH_ST) begin
            if (hazard) begin
                w_freeze = ONE;
            end else if (!imem_ready) begin
                w_bubble = ONE;
            end
        end else begin
            if (hazard) begin
                w_freeze = ONE;
            end else begin
                w_load_pc    = r_hold_pc4;
                w_load_instr = r_hold_instr;
            end
        end
    end

    // PC, FSM and hold buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= FETCH_ST;
            r_pc         <= RESET_PC;
            r_hold_instr <= '0;
            r_hold_pc4   <= '0;
        end else if (branch_taken) begin
            // Redirect wins over everything; any data returned now is dropped.
            r_state      <= FETCH_ST;
            r_pc         <= branch_addr;
            r_hold_instr <= '0;
            r_hold_pc4   <= '0;
        end else begin
            case (r_state)
                FETCH_ST: begin
                    if (imem_ready) begin
                        // The access completed, so advance even when stalled;
                        // the instruction is parked rather than refetched.
                        r_pc <= w_pc4;
                        if (hazard) begin
                            r_hold_instr <= imem_rdata;
                            r_hold_pc4   <= w_pc4;
                            r_state      <= HOLD_ST;
                        end
                    end
                end
                HOLD_ST: begin
                    if (!hazard) begin
                        r_state <= FETCH_ST;
                    end
                end
                default: r_state <= FETCH_ST;
            endcase
        end
    end

`ifdef FETCH_STALL_CNT_EN
    logic [31:0] r_stall_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_count <= '0;
        end else if (hazard && !branch_taken && (r_stall_count != 32'hFFFF_FFFF)) begin
            r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign stall_count = r_stall_count;
`endif

    fetch_stage_if_id_reg #(
        .WORD_LEN (WORD_LEN)
    ) u_if_id_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_flush  (branch_taken),
        .i_freeze (w_freeze),
        .i_bubble (w_bubble),
        .i_pc     (w_load_pc),
        .i_instr  (w_load_instr),
        .o_valid  (if_id_valid),
        .o_pc     (if_id_pc),
        .o_instr  (if_id_instr)
    );

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Self-checking bench for fetch_stage. A transaction-level model (current PC,
// a queue of instructions fetched but not yet delivered to decode, and the
// IF/ID contents) predicts every output; directed sequences also check
// hand-computed literal values. Inputs change on the falling edge, outputs
// are compared on the falling edge after each rising edge.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    localparam int          W      = 32;
    localparam logic [31:0] RST_PC = 32'h0;

    logic          clk          = 1'b0;
    logic          rst_n        = 1'b0;
    logic          hazard       = 1'b0;
    logic          branch_taken = 1'b0;
    logic [W-1:0]  branch_addr  = '0;
    logic          imem_ready   = 1'b0;
    logic [W-1:0]  imem_rdata   = '0;
    logic          imem_req;
    logic [W-1:0]  imem_addr;
    logic          if_id_valid;
    logic [W-1:0]  if_id_pc;
    logic [W-1:0]  if_id_instr;
`ifdef FETCH_STALL_CNT_EN
    logic [31:0]   stall_count;
`endif

    fetch_stage #(
        .WORD_LEN (W),
        .RESET_PC (RST_PC)
    ) dut (
`ifdef FETCH_STALL_CNT_EN
        .stall_count  (stall_count),
`endif
        .clk          (clk),
        .rst_n        (rst_n),
        .hazard       (hazard),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .if_id_valid  (if_id_valid),
        .if_id_pc     (if_id_pc),
        .if_id_instr  (if_id_instr)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state.
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_pc4;
    logic [31:0] m_instr;
    logic [31:0] m_cnt;
    logic [63:0] m_pending[$];   // {pc+4, instr} fetched but not yet in IF/ID

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc    = RST_PC;
        m_valid = 1'b0;
        m_pc4   = '0;
        m_instr = '0;
        m_cnt   = '0;
        m_pending.delete();
    endtask

    // One clock of the fetch rules, at transaction level.
    task automatic model_step(input logic h, input logic b, input logic [31:0] ba,
                              input logic rdy, input logic [31:0] rd);
        if (h && !b && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        if (b) begin
            m_pc    = ba;
            m_valid = 1'b0;
            m_pc4   = '0;
            m_instr = '0;
            m_pending.delete();
        end else if (m_pending.size() != 0) begin
            if (!h) begin
                {m_pc4, m_instr} = m_pending.pop_front();
                m_valid = 1'b1;
            end
        end else if (rdy) begin
            if (h) begin
                m_pending.push_back({m_pc + 32'd4, rd});
            end else begin
                m_valid = 1'b1;
                m_pc4   = m_pc + 32'd4;
                m_instr = rd;
            end
            m_pc = m_pc + 32'd4;
        end else if (!h) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic compare_model();
        check("imem_req", {31'd0, imem_req}, {31'd0, m_pending.size() == 0});
        check("imem_addr", imem_addr, m_pc);
        check("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
        check("if_id_pc", if_id_pc, m_pc4);
        check("if_id_instr", if_id_instr, m_instr);
`ifdef FETCH_STALL_CNT_EN
        check("stall_count", stall_count, m_cnt);
`endif
    endtask

    // Called at a falling edge: drive, clock, update model, compare.
    // Memory only answers while a request is present.
    task automatic step(input logic h, input logic b, input logic [31:0] ba,
                        input logic rdy, input logic [31:0] rd);
        logic rdy_eff;
        rdy_eff      = rdy && imem_req;
        hazard       = h;
        branch_taken = b;
        branch_addr  = ba;
        imem_ready   = rdy_eff;
        imem_rdata   = rd;
        @(posedge clk);
        model_step(h, b, ba, rdy_eff, rd);
        @(negedge clk);
        compare_model();
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset state.
        check("rst_req", {31'd0, imem_req}, 32'd1);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", {31'd0, if_id_valid}, 32'd0);
        check("rst_pc4", if_id_pc, 32'h0);
        check("rst_instr", if_id_instr, 32'h0);
        compare_model();

        // Zero-wait streaming: 0, 4, 8.
        step(0, 0, 0, 1, 32'hA000_0000);
        check("s0_pc4", if_id_pc, 32'd4);
        check("s0_valid", {31'd0, if_id_valid}, 32'd1);
        step(0, 0, 0, 1, 32'hA000_0004);
        check("s1_pc4", if_id_pc, 32'd8);
        check("s1_addr", imem_addr, 32'd8);

        // Two wait cycles at 8.
        step(0, 0, 0, 0, 32'h0);
        check("w0_valid", {31'd0, if_id_valid}, 32'd0);
        check("w0_addr", imem_addr, 32'd8);
        step(0, 0, 0, 0, 32'h0);
        check("w1_valid", {31'd0, if_id_valid}, 32'd0);
        check("w1_addr", imem_addr, 32'd8);
        step(0, 0, 0, 1, 32'hA000_0008);
        check("w2_pc4", if_id_pc, 32'd12);
        check("w2_instr", if_id_instr, 32'hA000_0008);

        // Stall for 3 cycles while memory returns 0xE3A01001 at 12.
        step(1, 0, 0, 1, 32'hE3A0_1001);
        check("h0_req", {31'd0, imem_req}, 32'd0);
        check("h0_pc4", if_id_pc, 32'd12);
        step(1, 0, 0, 1, 32'hDEAD_BEEF);
        step(1, 0, 0, 1, 32'hDEAD_BEEF);
        check("h2_instr", if_id_instr, 32'hA000_0008);
        step(0, 0, 0, 0, 32'h0);
        check("h3_instr", if_id_instr, 32'hE3A0_1001);
        check("h3_pc4", if_id_pc, 32'd16);
        check("h3_addr_no_refetch", imem_addr, 32'd16);
        check("h3_req", {31'd0, imem_req}, 32'd1);

        // Branch during a stall with a pending hold entry.
        step(1, 0, 0, 1, 32'h1111_1111);
        check("b0_req", {31'd0, imem_req}, 32'd0);
        step(1, 1, 32'h40, 0, 32'h0);
        check("b1_valid", {31'd0, if_id_valid}, 32'd0);
        check("b1_instr", if_id_instr, 32'h0);
        check("b1_addr", imem_addr, 32'h40);
        step(0, 0, 0, 1, 32'h2222_2222);
        check("b2_pc4", if_id_pc, 32'h44);
        check("b2_instr_not_held", if_id_instr, 32'h2222_2222);

        // PC wrap.
        step(0, 1, 32'hFFFF_FFFC, 1, 32'h3333_3333);
        check("wr0_addr", imem_addr, 32'hFFFF_FFFC);
        step(0, 0, 0, 1, 32'h4444_4444);
        check("wr1_pc4", if_id_pc, 32'h0);
        check("wr1_addr", imem_addr, 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic        h, b, r;
            logic [31:0] ba;
            h  = ($urandom_range(0, 3) == 0);
            b  = ($urandom_range(0, 15) == 0);
            r  = ($urandom_range(0, 9) < 7);
            case ($urandom_range(0, 3))
                0:       ba = 32'hFFFF_FFF8;
                1:       ba = $urandom();
                default: ba = $urandom() & 32'hFFFF_FFFC;
            endcase
            step(h, b, ba, r, $urandom());
        end

        // Asynchronous reset mid-run, asserted away from a clock edge.
        hazard = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", {31'd0, if_id_valid}, 32'd0);
        check("arst_addr", imem_addr, RST_PC);
        check("arst_req", {31'd0, imem_req}, 32'd1);
`ifdef FETCH_STALL_CNT_EN
        check("arst_cnt", stall_count, 32'd0);
`endif
        model_reset();
        @(negedge clk);
        rst_n  = 1'b1;
        hazard = 1'b0;
        compare_model();

        // Five hazard cycles, one coinciding with a branch.
        step(1, 0, 0, 0, 32'h0);
        step(1, 0, 0, 0, 32'h0);
        step(1, 1, 32'h80, 0, 32'h0);
        step(1, 0, 0, 0, 32'h0);
        step(1, 0, 0, 0, 32'h0);
        check("cnt_addr", imem_addr, 32'h80);
`ifdef FETCH_STALL_CNT_EN
        check("cnt_value", stall_count, 32'd4);
`endif
        step(0, 0, 0, 1, 32'h5555_5555);
        check("cnt_end_pc4", if_id_pc, 32'h84);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_fetch_stage
